// File: rtl/gshare_predictor.sv
// gshare_predictor
//   Conditional-branch direction predictor for the fetch path. A pattern
//   history table (PHT) of saturating counters is indexed by PC bits, XORed
//   with the speculative global history when GSHARE=1. A fetch lookup returns
//   a registered prediction one cycle later. The EX stage trains the counters
//   and, after a mispredict, repairs the speculative history from the
//   checkpoint that travelled with the branch. After reset the PHT is filled
//   by a sweep, so the table itself carries no reset and can map onto RAM.
//
//   State table:
//     state   | meaning
//     ST_INIT | sweeping INIT_CTR into every PHT entry; all requests ignored
//     ST_RUN  | normal lookup / speculate / resolve operation
//
//   Ports:
//     clk_i, rst_i              clock, synchronous active-high reset
//     init_busy_o               high while the sweep runs
//     lookup_valid_i/pc_i       fetch lookup request
//     pred_*_o                  registered prediction and its checkpoint
//     spec_push_i/taken_i       shift a predicted direction into spec history
//     resolve_*_i               EX-stage resolution, training and repair
//     spec_ghist_o, ret_ghist_o speculative and retired global history
//     branch_cnt_o/mispred_cnt_o resolved-branch and mispredict counters
module gshare_predictor #(
    parameter int IDX_BITS  = 8,
    parameter int HIST_BITS = 8,
    parameter int CTR_BITS  = 2,
    parameter int PC_LSB    = 2,
    parameter int INIT_CTR  = 1,
    parameter int GSHARE    = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    output logic                 init_busy_o,
    input  logic                 lookup_valid_i,
    input  logic [31:0]          lookup_pc_i,
    output logic                 pred_valid_o,
    output logic                 pred_taken_o,
    output logic [CTR_BITS-1:0]  pred_ctr_o,
    output logic [IDX_BITS-1:0]  pred_idx_o,
    output logic [HIST_BITS-1:0] pred_ghist_o,
    input  logic                 spec_push_i,
    input  logic                 spec_taken_i,
    input  logic                 resolve_valid_i,
    input  logic [IDX_BITS-1:0]  resolve_idx_i,
    input  logic                 resolve_taken_i,
    input  logic                 resolve_mispredict_i,
    input  logic [HIST_BITS-1:0] resolve_ghist_i,
    output logic [HIST_BITS-1:0] spec_ghist_o,
    output logic [HIST_BITS-1:0] ret_ghist_o,
    output logic [31:0]          branch_cnt_o,
    output logic [31:0]          mispred_cnt_o
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(INIT_CTR);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [CTR_BITS-1:0]  pht_q [ENTRIES];

    logic [0:0]           state_q, state_d;
    logic [IDX_BITS-1:0]  init_idx_q, init_idx_d;
    logic [HIST_BITS-1:0] spec_ghist_q, spec_ghist_d;
    logic [HIST_BITS-1:0] ret_ghist_q, ret_ghist_d;
    logic [31:0]          branch_cnt_q, branch_cnt_d;
    logic [31:0]          mispred_cnt_q, mispred_cnt_d;
    logic                 pred_valid_q;
    logic [CTR_BITS-1:0]  pred_ctr_q;
    logic [IDX_BITS-1:0]  pred_idx_q;
    logic [HIST_BITS-1:0] pred_ghist_q;

    logic                 running;
    logic                 do_lookup;
    logic                 do_resolve;
    logic [IDX_BITS-1:0]  pc_idx;
    logic [IDX_BITS-1:0]  lookup_idx;
    logic [CTR_BITS-1:0]  resolve_old;
    logic [CTR_BITS-1:0]  resolve_new;
    logic                 unused_pc;

    // Shift-in that also works for a 1-bit history, where it simply loads b.
    function automatic logic [HIST_BITS-1:0] shift_in(input logic [HIST_BITS-1:0] h,
                                                      input logic b);
        logic [HIST_BITS-1:0] r;
        r    = h << 1;
        r[0] = b;
        return r;
    endfunction

    assign unused_pc  = ^lookup_pc_i;
    assign running    = (state_q == ST_RUN);
    assign do_lookup  = running && lookup_valid_i;
    assign do_resolve = running && resolve_valid_i;
    assign pc_idx     = lookup_pc_i[PC_LSB+IDX_BITS-1:PC_LSB];

    always_comb begin
        lookup_idx = pc_idx;
        if (GSHARE != 0) begin
            lookup_idx = pc_idx ^ IDX_BITS'(spec_ghist_q);
        end
    end

    always_comb begin
        resolve_old = pht_q[resolve_idx_i];
        resolve_new = resolve_old;
        if (resolve_taken_i) begin
            if (resolve_old != CTR_MAX) resolve_new = resolve_old + 1'b1;
        end else begin
            if (resolve_old != '0) resolve_new = resolve_old - 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        init_idx_d    = init_idx_q;
        spec_ghist_d  = spec_ghist_q;
        ret_ghist_d   = ret_ghist_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (state_q == ST_INIT) begin
            init_idx_d = init_idx_q + 1'b1;
            if (init_idx_q == '1) state_d = ST_RUN;
        end else begin
            // A repair rewinds to the branch's checkpoint, so any push issued
            // in the same cycle belongs to the squashed path and is dropped.
            if (resolve_valid_i && resolve_mispredict_i) begin
                spec_ghist_d = shift_in(resolve_ghist_i, resolve_taken_i);
            end else if (spec_push_i) begin
                spec_ghist_d = shift_in(spec_ghist_q, spec_taken_i);
            end
            if (resolve_valid_i) begin
                ret_ghist_d  = shift_in(ret_ghist_q, resolve_taken_i);
                branch_cnt_d = branch_cnt_q + 32'd1;
                if (resolve_mispredict_i) mispred_cnt_d = mispred_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_INIT;
            init_idx_q    <= '0;
            spec_ghist_q  <= '0;
            ret_ghist_q   <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            init_idx_q    <= init_idx_d;
            spec_ghist_q  <= spec_ghist_d;
            ret_ghist_q   <= ret_ghist_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // Table has no reset; the sweep gives it a defined value.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == ST_INIT) begin
                pht_q[init_idx_q] <= CTR_INIT;
            end else if (do_resolve) begin
                pht_q[resolve_idx_i] <= resolve_new;
            end
        end
    end

    // The read samples the array before this edge's write, giving read-first
    // behaviour on a same-index lookup/resolve collision.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pred_valid_q <= 1'b0;
            pred_ctr_q   <= '0;
            pred_idx_q   <= '0;
            pred_ghist_q <= '0;
        end else begin
            pred_valid_q <= do_lookup;
            if (do_lookup) begin
                pred_ctr_q   <= pht_q[lookup_idx];
                pred_idx_q   <= lookup_idx;
                pred_ghist_q <= spec_ghist_q;
            end
        end
    end

    assign init_busy_o   = (state_q == ST_INIT);
    assign pred_valid_o  = pred_valid_q;
    assign pred_ctr_o    = pred_ctr_q;
    assign pred_taken_o  = pred_ctr_q[CTR_BITS-1];
    assign pred_idx_o    = pred_idx_q;
    assign pred_ghist_o  = pred_ghist_q;
    assign spec_ghist_o  = spec_ghist_q;
    assign ret_ghist_o   = ret_ghist_q;
    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
Parametrised gshare conditional-branch direction predictor for the pipelined core's fetch path. A fetch-stage PC lookup returns a registered prediction one cycle later. The block keeps a speculative global history with checkpoint repair and a retired global history. On EX-stage resolution it trains the saturating counters and repairs history after a mispredict. The pattern table is initialised by a post-reset sweep FSM, so it maps onto BRAM/LUTRAM without a parallel reset.

Parameters:
IDX_BITS, 8, log2 of pattern-table entries
HIST_BITS, 8, global history length; must satisfy 1 <= HIST_BITS <= IDX_BITS
CTR_BITS, 2, saturating counter width (>= 1)
PC_LSB, 2, lowest PC bit used for indexing
INIT_CTR, 1, counter value written on init (weakly not-taken for CTR_BITS=2)
GSHARE, 1, 1 = index is PC xor history; 0 = bimodal (history ignored for indexing, still tracked)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
init_busy  out  1  high while the table sweep runs
lookup_valid  in  1  fetch lookup request
lookup_pc  in  32  fetch PC
pred_valid  out  1  registered; prediction valid this cycle
pred_taken  out  1  counter MSB
pred_ctr  out  CTR_BITS  counter value read
pred_idx  out  IDX_BITS  table index used (carried down the pipe)
pred_ghist  out  HIST_BITS  speculative history snapshot used for the index (checkpoint)
spec_push  in  1  fetch predicted a conditional branch; shift spec_taken into speculative history
spec_taken  in  1  predicted direction
resolve_valid  in  1  conditional branch resolved in EX
resolve_idx  in  IDX_BITS  pred_idx carried with the branch
resolve_taken  in  1  actual direction
resolve_mispredict  in  1  actual direction differs from prediction
resolve_ghist  in  HIST_BITS  pred_ghist carried with the branch
spec_ghist  out  HIST_BITS  current speculative history
ret_ghist  out  HIST_BITS  retired history
branch_cnt  out  32  resolved-branch count
mispred_cnt  out  32  mispredict count

Behaviour:
- Reset (rst high, any state): state=INIT; init_idx=0; spec_ghist=0; ret_ghist=0; branch_cnt=0; mispred_cnt=0; pred_valid=0; pred_taken=0; pred_ctr=0; pred_idx=0; pred_ghist=0; init_busy=1.
- A reset mid-sweep or mid-run restarts the sweep from index 0. All training is discarded.
- INIT: each cycle writes INIT_CTR to table[init_idx], then init_idx++. After the write of index 2^IDX_BITS-1, state goes to RUN. init_busy falls exactly 2^IDX_BITS cycles after the first cycle with rst low.
- During INIT, lookup, spec_push and resolve are ignored, and pred_valid stays 0.
- Index: pcidx = lookup_pc[PC_LSB+IDX_BITS-1:PC_LSB]. With GSHARE=1, idx = pcidx xor zero-extended spec_ghist (history in the low bits). With GSHARE=0, idx = pcidx.
- Lookup latency is 1 cycle. With lookup_valid at cycle t in RUN, at t+1: pred_valid=1, pred_idx=idx, pred_ctr=table[idx], pred_taken=pred_ctr[CTR_BITS-1], pred_ghist=spec_ghist as sampled at t. Otherwise pred_valid=0 and the other pred_* outputs hold their previous values.
- Read/write collision (lookup idx equals a resolve_idx written in the same cycle): read-first, so the response shows the pre-update counter.
- Resolve in RUN: table[resolve_idx] saturating +1 if taken, else saturating -1. Range is 0 to 2^CTR_BITS-1, with no wrap.
- Resolve in RUN also sets ret_ghist <= {ret_ghist[HIST_BITS-2:0], resolve_taken} and branch_cnt += 1. When resolve_mispredict is set, mispred_cnt += 1. Both counters wrap modulo 2^32.
- Speculative history: spec_push sets spec_ghist <= {spec_ghist[HIST_BITS-2:0], spec_taken}.
- Mispredict repair: when resolve_valid and resolve_mispredict are both high, spec_ghist <= {resolve_ghist[HIST_BITS-2:0], resolve_taken}. Repair has priority over a same-cycle spec_push, which is dropped.
- When HIST_BITS=1, the shift reduces to loading the new bit.
- A lookup in the same cycle as a push or repair indexes with the pre-update spec_ghist.
- resolve_mispredict without resolve_valid has no effect.

Test Plan:
- Init timing and default prediction (defaults): rst high 2 cycles, then low → init_busy high for exactly 256 cycles. Then lookup_pc=0x00000040 → next cycle pred_valid=1, pred_idx=0x10, pred_ctr=1, pred_taken=0, pred_ghist=0x00.
- Counter saturation: resolve idx 0x10 taken 3× → lookup shows ctr=3, taken=1 (not 0). Then 5× not-taken → ctr=0 with no underflow wrap. branch_cnt=8, mispred_cnt=0.
- History indexing: spec_push taken 3× → spec_ghist=0x07. Lookup pc 0x40 → pred_idx=0x17, pred_ghist=0x07. Repeat with GSHARE=0 → pred_idx=0x10.
- Repair priority: spec_ghist=0x07. Same cycle: resolve_valid=1, mispredict=1, resolve_ghist=0x03, resolve_taken=0, plus spec_push=1, spec_taken=1 → spec_ghist=0x06, ret_ghist shifts in 0, mispred_cnt=1.
- Collision and INIT gating: lookup and resolve on idx 0x10 (ctr 1, taken) in the same cycle → pred_ctr=1, and the next lookup shows 2. Lookups and resolves during INIT → pred_valid=0 and all counters unchanged.
- Reset mid-run: train idx 0x10 to 3, then pulse rst 1 cycle → histories and counters zero, init_busy high for 256 cycles, then lookup idx 0x10 gives ctr=1.
